// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with alternating tie-break, a
// mandatory idle cycle between grants and a combinational slave-side mux.
// Optional stalled-strobe timeout is enabled by defining WB_ARBITER2_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int unsigned ADDRESS_WIDTH  = 14,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SEL_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 m_CYC,
  input  logic [1:0]                 m_STB,
  input  logic [1:0]                 m_WE,
  input  logic [2*ADDRESS_WIDTH-1:0] m_ADR,
  input  logic [2*DATA_WIDTH-1:0]    m_DAT_MOSI,
  input  logic [2*SEL_WIDTH-1:0]     m_SEL,
  output logic [1:0]                 m_ACK,
  output logic [1:0]                 m_ERR,
  output logic [DATA_WIDTH-1:0]      m_DAT_MISO,
  output logic                       s_CYC,
  output logic                       s_STB,
  output logic                       s_WE,
  output logic [ADDRESS_WIDTH-1:0]   s_ADR,
  output logic [DATA_WIDTH-1:0]      s_DAT_MOSI,
  output logic [SEL_WIDTH-1:0]       s_SEL,
  input  logic                       s_ACK,
  input  logic [DATA_WIDTH-1:0]      s_DAT_MISO,
  output logic [1:0]                 grant
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = SEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_served;
  logic   last_served_next;
  logic   sel;
  logic   stb_mask;

  // State and tie-break history register
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_next;
      last_served <= last_served_next;
    end
  end

  // Next-state: grant from IDLE only, release when the owner drops CYC
  always_comb begin
    state_next       = state;
    last_served_next = last_served;
    case (state)
      IDLE: begin
        case (m_CYC)
          2'b01:   state_next = GNT0;
          2'b10:   state_next = GNT1;
          2'b11:   state_next = last_served ? GNT0 : GNT1;
          default: state_next = IDLE;
        endcase
      end
      GNT0: begin
        if (!m_CYC[0]) begin
          state_next       = IDLE;
          last_served_next = 1'b0;
        end
      end
      GNT1: begin
        if (!m_CYC[1]) begin
          state_next       = IDLE;
          last_served_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant = {state == GNT1, state == GNT0};
  assign sel   = (state == GNT1);

  // Slave-side mux of the granted master; all zero while idle
  always_comb begin
    s_CYC      = 1'b0;
    s_STB      = 1'b0;
    s_WE       = 1'b0;
    s_ADR      = '0;
    s_DAT_MOSI = '0;
    s_SEL      = '0;
    if (state != IDLE) begin
      s_CYC      = m_CYC[sel];
      s_STB      = m_STB[sel] & ~stb_mask;
      s_WE       = m_WE[sel];
      s_ADR      = sel ? m_ADR[AW +: AW]      : m_ADR[0 +: AW];
      s_DAT_MOSI = sel ? m_DAT_MOSI[DW +: DW] : m_DAT_MOSI[0 +: DW];
      s_SEL      = sel ? m_SEL[SW +: SW]      : m_SEL[0 +: SW];
    end
  end

  assign m_ACK      = {2{s_ACK & s_STB}} & grant;
  assign m_DAT_MISO = s_DAT_MISO;

`ifdef WB_ARBITER2_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt;
  logic       mask_q;
  logic [1:0] err_q;

  // Stalled-strobe counter, error pulse and strobe mask
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= 8'd0;
      mask_q <= 1'b0;
      err_q  <= 2'b00;
    end else begin
      err_q <= 2'b00;
      if ((state_next != state) || !s_STB || s_ACK) begin
        to_cnt <= 8'd0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt <= 8'd0;
        err_q  <= grant;
        mask_q <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 8'd1;
      end
      if (mask_q && ((state == IDLE) || !m_STB[sel] || !m_CYC[sel])) begin
        mask_q <= 1'b0;
      end
    end
  end

  assign stb_mask = mask_q;
  assign m_ERR    = err_q;
`else
  assign stb_mask = 1'b0;
  assign m_ERR    = 2'b00;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural owner/queue-free model of the arbiter.
module tb_wb_arbiter2;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [1:0]        m_CYC, m_STB, m_WE;
  logic [2*AW-1:0]   m_ADR;
  logic [2*DW-1:0]   m_DAT_MOSI;
  logic [2*SW-1:0]   m_SEL;
  logic [1:0]        m_ACK, m_ERR;
  logic [DW-1:0]     m_DAT_MISO;
  logic              s_CYC, s_STB, s_WE;
  logic [AW-1:0]     s_ADR;
  logic [DW-1:0]     s_DAT_MOSI;
  logic [SW-1:0]     s_SEL;
  logic              s_ACK;
  logic [DW-1:0]     s_DAT_MISO;
  logic [1:0]        grant;

  wb_arbiter2 #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE), .m_ADR(m_ADR),
    .m_DAT_MOSI(m_DAT_MOSI), .m_SEL(m_SEL),
    .m_ACK(m_ACK), .m_ERR(m_ERR), .m_DAT_MISO(m_DAT_MISO),
    .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
    .s_DAT_MOSI(s_DAT_MOSI), .s_SEL(s_SEL),
    .s_ACK(s_ACK), .s_DAT_MISO(s_DAT_MISO), .grant(grant)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: owner is -1 when nobody holds the bus, else the master index
  int         owner = -1;
  int         last  = 1;
  int         stall = 0;
  bit         mask  = 1'b0;
  logic [1:0] err   = 2'b00;
  logic       e_stb_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare every DUT output against the model for the current inputs
  task automatic settle();
    logic [1:0]    eg, eack;
    logic          ecyc, estb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW-1:0] esel;
    #1;
    eg = 2'b00; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    eadr = '0; edat = '0; esel = '0;
    if (owner >= 0) begin
      eg   = 2'(1 << owner);
      ecyc = m_CYC[owner];
      estb = m_STB[owner] & ~mask;
      ewe  = m_WE[owner];
      eadr = m_ADR[owner*AW +: AW];
      edat = m_DAT_MOSI[owner*DW +: DW];
      esel = m_SEL[owner*SW +: SW];
    end
    eack = (s_ACK && estb) ? eg : 2'b00;
    e_stb_q = estb;
    chk("grant", 64'(grant), 64'(eg));
    chk("s_CYC", 64'(s_CYC), 64'(ecyc));
    chk("s_STB", 64'(s_STB), 64'(estb));
    chk("s_WE", 64'(s_WE), 64'(ewe));
    chk("s_ADR", 64'(s_ADR), 64'(eadr));
    chk("s_DAT_MOSI", 64'(s_DAT_MOSI), 64'(edat));
    chk("s_SEL", 64'(s_SEL), 64'(esel));
    chk("m_ACK", 64'(m_ACK), 64'(eack));
    chk("m_ERR", 64'(m_ERR), 64'(err));
    chk("m_DAT_MISO", 64'(m_DAT_MISO), 64'(s_DAT_MISO));
  endtask

  // Clock edge: advance the model with the inputs held across the edge
  task automatic tick();
    int nxt;
    @(posedge clk);
    if (reset) begin
      owner = -1; last = 1; mask = 1'b0; stall = 0; err = 2'b00;
    end else begin
      nxt = owner;
      if (owner < 0) begin
        if (m_CYC == 2'b01) nxt = 0;
        else if (m_CYC == 2'b10) nxt = 1;
        else if (m_CYC == 2'b11) nxt = 1 - last;
      end else if (!m_CYC[owner]) begin
        nxt  = -1;
        last = owner;
      end
`ifdef WB_ARBITER2_TIMEOUT_EN
      err = 2'b00;
      if (nxt != owner || !e_stb_q || s_ACK) stall = 0;
      else if (stall + 1 == int'(TO)) begin
        stall = 0;
        err   = 2'(1 << owner);
        mask  = 1'b1;
      end else stall++;
      if (mask && (owner < 0 || !m_STB[owner] || !m_CYC[owner]) && !(err != 2'b00))
        mask = 1'b0;
`endif
      owner = nxt;
    end
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sl);
    m_CYC[i] = cyc; m_STB[i] = stb; m_WE[i] = we;
    m_ADR[i*AW +: AW] = adr;
    m_DAT_MOSI[i*DW +: DW] = dat;
    m_SEL[i*SW +: SW] = sl;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_CYC = 2'b00; m_STB = 2'b00; s_ACK = 1'b0;
    tick();
    settle();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_s_CYC", 64'(s_CYC), 64'h0);
    chk("rst_m_ERR", 64'(m_ERR), 64'h0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_CYC = '0; m_STB = '0; m_WE = '0; m_ADR = '0; m_DAT_MOSI = '0; m_SEL = '0;
    s_ACK = 1'b0; s_DAT_MISO = '0;
    @(negedge clk);
    do_reset();

    // Single request: one-cycle grant latency, ACK routed, address muxed
    set_m(0, 1, 1, 1, 14'h123, 32'h1111_2222, 4'hF);
    settle(); chk("lat_grant0", 64'(grant), 64'h0); tick();
    s_ACK = 1'b1;
    settle();
    chk("single_grant", 64'(grant), 64'h1);
    chk("single_adr", 64'(s_ADR), 64'h123);
    chk("single_ack", 64'(m_ACK), 64'h1);
    tick();
    s_ACK = 1'b0; m_STB = 2'b00;
    settle(); chk("single_ack_end", 64'(m_ACK), 64'h0); tick();
    m_CYC = 2'b00; settle(); tick();

    // Tie from reset, dead cycle, alternation, hold, read data
    do_reset();
    m_CYC = 2'b11; settle(); tick();
    settle(); chk("tie_first", 64'(grant), 64'h1); tick();
    m_CYC = 2'b10; settle(); tick();
    settle(); chk("dead_cycle", 64'(grant), 64'h0); tick();
    set_m(1, 1, 1, 0, 14'h2AB, 32'h0, 4'h3);
    s_ACK = 1'b1; s_DAT_MISO = 32'hDEADBEEF;
    settle();
    chk("tie_second", 64'(grant), 64'h2);
    chk("rd_data", 64'(m_DAT_MISO), 64'hDEADBEEF);
    chk("rd_ack", 64'(m_ACK), 64'h2);
    tick();
    m_CYC[0] = 1'b1; m_STB[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_DAT_MISO = 32'(k);
      settle();
      chk("hold_grant", 64'(grant), 64'h2);
      chk("hold_ack", 64'(m_ACK), 64'h2);
      tick();
    end
    s_ACK = 1'b0; m_CYC = 2'b01; m_STB = 2'b00; settle(); tick();
    m_CYC = 2'b11; settle(); tick();
    settle(); chk("tie_alternate", 64'(grant), 64'h1);

    // Reset while master 0 strobes
    m_STB = 2'b01; reset = 1'b1; tick();
    reset = 1'b0; s_ACK = 1'b1;
    settle();
    chk("rst_mid_grant", 64'(grant), 64'h0);
    chk("rst_mid_cyc", 64'(s_CYC), 64'h0);
    chk("rst_mid_ack", 64'(m_ACK), 64'h0);
    tick();

    // Stalled strobe, slave never acknowledges
    do_reset();
    set_m(0, 1, 1, 0, 14'h5, 32'h5, 4'h1); set_m(1, 0, 0, 0, 0, 0, 0);
    settle(); tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) m_STB[0] = 1'b0;
      if (k == 8) m_STB[0] = 1'b1;
      settle();
`ifdef WB_ARBITER2_TIMEOUT_EN
      if (k == 4) chk("to_before", 64'(m_ERR), 64'h0);
      if (k == 5) chk("to_pulse", 64'(m_ERR), 64'h1);
      if (k == 6) chk("to_pulse_end", 64'(m_ERR), 64'h0);
      if (k == 6) chk("to_masked", 64'(s_STB), 64'h0);
      if (k == 8) chk("to_unmasked", 64'(s_STB), 64'h1);
`else
      if (k == 5) chk("no_to_err", 64'(m_ERR), 64'h0);
      if (k == 6) chk("no_to_stb", 64'(s_STB), 64'h1);
`endif
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) m_CYC[i] = ~m_CYC[i];
        m_STB[i] = m_CYC[i] & ($urandom_range(0, 3) != 0);
        m_WE[i]  = 1'($urandom);
        m_ADR[i*AW +: AW]      = AW'($urandom);
        m_DAT_MOSI[i*DW +: DW] = DW'($urandom);
        m_SEL[i*SW +: SW]      = SW'($urandom);
      end
      s_ACK      = ($urandom_range(0, 2) == 0);
      s_DAT_MISO = DW'($urandom);
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
